// File: rtl/my_package.sv
// Shared widths and types for the adder datapath and its downstream sum accumulator.
package my_package;
   localparam int my_width     = 8;
   localparam int MY_ACC_CNT_W = 4;

   typedef logic [my_width:0] my_sum_t;

   typedef enum logic [1:0] {
      ACC_IDLE,
      ACC_ACCUM,
      ACC_HOLD
   } acc_state_e;
endpackage

// File: rtl/my_sum_accum.sv
// Accumulates frames of len+1 sums and emits a total and a count. The result is valid the
// cycle after the final accept. Input is stalled while a result waits for out_ready.
module my_sum_accum
   import my_package::*;
#(
   parameter  int IN_W  = my_width + 1,
   parameter  int CNT_W = MY_ACC_CNT_W,
   localparam int ACC_W = IN_W + CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [CNT_W-1:0] len,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W:0]   out_count
);

   localparam logic [CNT_W:0] CNT_ONE = CNT_W'(1);

   acc_state_e       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [ACC_W-1:0] in_ext;

   assign in_ext = {{CNT_W{1'b0}}, in_data};

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ACC_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               len_d   = len;
               acc_d   = in_ext;
               cnt_d   = CNT_ONE;
               state_d = (len == '0) ? ACC_HOLD : ACC_ACCUM;
            end
         end
         ACC_ACCUM: begin
            in_ready = 1'b1;
            if (in_valid) begin
               acc_d = acc_q + in_ext;
               cnt_d = cnt_q + CNT_ONE;
               // cnt_q counts samples before this one, so equality means this is the last
               if ((cnt_q == {1'b0, len_q}) || flush) begin
                  state_d = ACC_HOLD;
               end
            end else if (flush) begin
               state_d = ACC_HOLD;
            end
         end
         ACC_HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ACC_IDLE;
            end
         end
         default: state_d = ACC_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= ACC_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
      end
   end

   assign out_sum   = acc_q;
   assign out_count = cnt_q;

endmodule

// File: tb/tb_my_sum_accum.sv
// Directed and randomized bench for my_sum_accum against a frame-level queue model.
module tb_my_sum_accum;
   import my_package::*;

   localparam int IN_W  = my_width + 1;
   localparam int CNT_W = MY_ACC_CNT_W;
   localparam int ACC_W = IN_W + CNT_W;

   logic             clock;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic [CNT_W-1:0] len;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_sum;
   logic [CNT_W:0]   out_count;

   my_sum_accum dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .len       (len),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_count (out_count)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int n_checks = 0;
   int n_err    = 0;

   // Model: samples of the current/last frame, its target length, and whether it is closed.
   int m_q[$];
   int m_target = 0;
   bit m_closed = 1'b0;
   bit m_pending = 1'b0;

   function automatic int m_sum();
      int s = 0;
      foreach (m_q[i]) s += m_q[i];
      return s;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      if (!reset) begin
         m_q.delete();
         m_closed  = 1'b0;
         m_pending = 1'b0;
      end else if (m_pending) begin
         if (out_ready) m_pending = 1'b0;
      end else if (in_valid) begin
         if (m_q.size() == 0 || m_closed) begin
            m_q.delete();
            m_q.push_back(int'(in_data));
            m_target = int'(len) + 1;
            m_closed = 1'b0;
            if (m_target == 1) begin
               m_closed  = 1'b1;
               m_pending = 1'b1;
            end
         end else begin
            m_q.push_back(int'(in_data));
            if (m_q.size() == m_target || flush) begin
               m_closed  = 1'b1;
               m_pending = 1'b1;
            end
         end
      end else if (flush && m_q.size() > 0 && !m_closed) begin
         m_closed  = 1'b1;
         m_pending = 1'b1;
      end
   endtask

   task automatic cycle();
      @(negedge clock);
      chk("out_valid", 32'(out_valid), 32'(m_pending));
      chk("in_ready", 32'(in_ready), 32'(!m_pending));
      chk("out_sum", 32'(out_sum), m_sum());
      chk("out_count", 32'(out_count), m_q.size());
      @(posedge clock);
      model_step();
      #1;
   endtask

   task automatic send(input int d, input int l, input bit f);
      in_valid = 1'b1;
      in_data  = IN_W'(d);
      len      = CNT_W'(l);
      flush    = f;
      cycle();
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic expect_result(input string tag, input int s, input int c);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_sum"}, 32'(out_sum), 32'(s));
      chk({tag, "_count"}, 32'(out_count), 32'(c));
   endtask

   task automatic handshake();
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b0; in_valid = 1'b0; in_data = '0; len = '0; flush = 1'b0; out_ready = 1'b0;
      cycle();
      cycle();
      reset = 1'b1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_sum", 32'(out_sum), 32'd0);
      chk("rst_count", 32'(out_count), 32'd0);

      // Three-sample frame back to back
      send(10, 2, 0); send(20, 2, 0); send(30, 2, 0);
      expect_result("t1", 60, 3);
      cycle();
      handshake();

      // Full-length frame of maximum values
      for (int i = 0; i < 16; i++) send(511, 15, 0);
      expect_result("t2", 8176, 16);
      handshake();

      // Single-sample frame, then backpressure with in_valid held high
      send(7, 0, 0);
      expect_result("t3", 7, 1);
      in_valid = 1'b1; in_data = IN_W'(9); len = CNT_W'(3);
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("t4_stall_ready", 32'(in_ready), 32'd0);
         expect_result("t4_hold", 7, 1);
      end
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      chk("t4_idle_ready", 32'(in_ready), 32'd1);
      chk("t4_idle_valid", 32'(out_valid), 32'd0);
      cycle();
      in_valid = 1'b0;
      chk("t4_first_sum", 32'(out_sum), 32'd9);
      chk("t4_first_count", 32'(out_count), 32'd1);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      expect_result("t4_flushed", 9, 1);
      handshake();

      // Flush alone, then flush together with a sample
      send(5, 7, 0); send(6, 7, 0);
      flush = 1'b1; cycle(); flush = 1'b0;
      expect_result("t5a", 11, 2);
      handshake();
      send(5, 7, 0); send(6, 7, 0); send(4, 7, 1);
      expect_result("t5b", 15, 3);
      handshake();

      // Reset in the middle of a frame
      send(1, 7, 0); send(2, 7, 0); send(3, 7, 0);
      reset = 1'b0; cycle(); reset = 1'b1;
      chk("t6_valid", 32'(out_valid), 32'd0);
      chk("t6_ready", 32'(in_ready), 32'd1);
      chk("t6_sum", 32'(out_sum), 32'd0);
      send(3, 1, 0); send(4, 1, 0);
      expect_result("t6", 7, 2);
      handshake();

      // Random traffic
      for (int i = 0; i < 2000; i++) begin
         reset     = ($urandom_range(0, 99) != 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = ($urandom_range(0, 7) == 0) ? IN_W'(511) : IN_W'($urandom);
         len       = CNT_W'($urandom);
         flush     = ($urandom_range(0, 9) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
